// File: rtl/image_downscale_2x2.sv
// image_downscale_2x2: 2:1 video downscaler on the pixel clock.
// Modes: bypass, horizontal 2:1 with rounding, or 2x2 box average using a
// half-width line buffer of unrounded horizontal pair sums.
// Pipeline: accept edge (stage 0) -> stage 1 (pair sum, buffer access)
// -> stage 2 (rounding into o_pixel). Latency is two edges after acceptance
// in every mode.
module image_downscale_2x2 #(
  parameter int CH        = 3,
  parameter int CH_W      = 8,
  parameter int MAX_SRC_W = 1280,
  parameter int ADDR_W    = $clog2(MAX_SRC_W / 2)
) (
  input  logic                 pixclk_in,
  input  logic                 rst,
  input  logic                 vs_in,
  input  logic [1:0]           mode_in,
  input  logic                 de_in,
  input  logic [CH*CH_W-1:0]   i_pixel,
  output logic                 de_out,
  output logic [CH*CH_W-1:0]   o_pixel,
  output logic                 line_ovf
);

  localparam int X_W   = $clog2(MAX_SRC_W) + 1;
  localparam int H_W   = CH_W + 1;
  localparam int PIX_W = CH * CH_W;
  localparam int HB_W  = CH * H_W;
  localparam int DEPTH = MAX_SRC_W / 2;

  localparam logic [1:0] MODE_BYP = 2'b00;
  localparam logic [1:0] MODE_HOR = 2'b01;
  localparam logic [1:0] MODE_BOX = 2'b10;

  localparam logic [X_W-1:0] X_LIMIT = X_W'(MAX_SRC_W);
  localparam logic [X_W-1:0] X_SAT   = {X_W{1'b1}};
  localparam logic [X_W-1:0] X_ZERO  = {X_W{1'b0}};

  // Line/frame control state
  logic [1:0]        mode_r;
  logic [X_W-1:0]    x_r;
  logic              par_r;
  logic              de_prev_r;
  logic              line_ovf_r;
  logic [PIX_W-1:0]  p_r;

  // Stage 0: what the accepted pixel must do
  logic              a0_prod_r;
  logic              a0_wr_r;
  logic [1:0]        a0_kind_r;
  logic [PIX_W-1:0]  a0_pix_r;
  logic [ADDR_W-1:0] a0_addr_r;

  // Stage 1: pair sum and buffer read data
  logic              s1_vld_r;
  logic [1:0]        s1_kind_r;
  logic [PIX_W-1:0]  s1_pix_r;
  logic [HB_W-1:0]   s1_h_r;
  logic [HB_W-1:0]   rd_data_r;

  // Stage 2: output registers
  logic              de_out_r;
  logic [PIX_W-1:0]  o_pixel_r;

  // Line buffer of horizontal pair sums
  logic [HB_W-1:0]   mem_r [0:DEPTH-1];

  // Combinational helpers
  logic              de_fall_s;
  logic              acc_s;
  logic              ovf_s;
  logic              prod_s;
  logic              wr_s;
  logic [1:0]        mode_dec_s;
  logic [HB_W-1:0]   h_s;
  logic [PIX_W-1:0]  out_s;
  logic [H_W-1:0]    hcur_s;
  logic [H_W-1:0]    hbuf_s;
  logic [H_W-1:0]    hor_s;
  logic [H_W:0]      box_s;

  assign de_out   = de_out_r;
  assign o_pixel  = o_pixel_r;
  assign line_ovf = line_ovf_r;

  // Accept/overflow qualification and per-mode decision for the current pixel
  always_comb begin
    de_fall_s  = de_prev_r & ~de_in;
    acc_s      = de_in & ~vs_in & (x_r < X_LIMIT);
    ovf_s      = de_in & ~vs_in & (x_r >= X_LIMIT);
    mode_dec_s = (mode_in == 2'b11) ? MODE_BYP : mode_in;
    prod_s     = 1'b0;
    wr_s       = 1'b0;
    case (mode_r)
      MODE_BYP: begin
        prod_s = acc_s;
      end
      MODE_HOR: begin
        prod_s = acc_s & x_r[0];
      end
      MODE_BOX: begin
        prod_s = acc_s & x_r[0] & par_r;
        wr_s   = acc_s & x_r[0] & ~par_r;
      end
      default: begin
        prod_s = acc_s;
      end
    endcase
  end

  // Frame mode latch, x counter, line parity and sticky overflow flag
  always_ff @(posedge pixclk_in or posedge rst) begin
    if (rst) begin
      mode_r     <= MODE_BYP;
      x_r        <= X_ZERO;
      par_r      <= 1'b0;
      de_prev_r  <= 1'b0;
      line_ovf_r <= 1'b0;
    end else begin
      de_prev_r <= de_in;
      if (vs_in) begin
        mode_r     <= mode_dec_s;
        x_r        <= X_ZERO;
        par_r      <= 1'b0;
        line_ovf_r <= 1'b0;
      end else begin
        if (de_fall_s) begin
          x_r <= X_ZERO;
          if (x_r != X_ZERO) begin
            par_r <= ~par_r;
          end
        end else if (de_in && (x_r != X_SAT)) begin
          x_r <= x_r + X_W'(1);
        end
        if (ovf_s) begin
          line_ovf_r <= 1'b1;
        end
      end
    end
  end

  // Stage 0: hold the even pixel in P and capture the accepted pixel's job
  always_ff @(posedge pixclk_in or posedge rst) begin
    if (rst) begin
      p_r       <= {PIX_W{1'b0}};
      a0_prod_r <= 1'b0;
      a0_wr_r   <= 1'b0;
      a0_kind_r <= MODE_BYP;
      a0_pix_r  <= {PIX_W{1'b0}};
      a0_addr_r <= {ADDR_W{1'b0}};
    end else begin
      a0_prod_r <= prod_s;
      a0_wr_r   <= wr_s;
      if (acc_s) begin
        a0_kind_r <= mode_r;
        a0_pix_r  <= i_pixel;
        a0_addr_r <= x_r[ADDR_W:1];
        if (!x_r[0]) begin
          p_r <= i_pixel;
        end
      end
    end
  end

  // Per-channel unrounded horizontal pair sum of P and the stage-0 pixel
  always_comb begin
    h_s = {HB_W{1'b0}};
    for (int c = 0; c < CH; c++) begin
      h_s[c*H_W +: H_W] = {1'b0, p_r[c*CH_W +: CH_W]} + {1'b0, a0_pix_r[c*CH_W +: CH_W]};
    end
  end

  // Stage 1: register pair sum / pass-through pixel alongside the buffer read
  always_ff @(posedge pixclk_in or posedge rst) begin
    if (rst) begin
      s1_vld_r  <= 1'b0;
      s1_kind_r <= MODE_BYP;
      s1_pix_r  <= {PIX_W{1'b0}};
      s1_h_r    <= {HB_W{1'b0}};
    end else begin
      s1_vld_r <= a0_prod_r;
      if (a0_prod_r) begin
        s1_kind_r <= a0_kind_r;
        s1_pix_r  <= a0_pix_r;
        s1_h_r    <= h_s;
      end
    end
  end

  // Line buffer: even-line pair sums written, odd-line sums read back
  always_ff @(posedge pixclk_in) begin
    if (a0_wr_r) begin
      mem_r[a0_addr_r] <= h_s;
    end
    rd_data_r <= mem_r[a0_addr_r];
  end

  // Final per-channel rounding for the selected operation
  always_comb begin
    out_s  = {PIX_W{1'b0}};
    hcur_s = {H_W{1'b0}};
    hbuf_s = {H_W{1'b0}};
    hor_s  = {H_W{1'b0}};
    box_s  = {(H_W+1){1'b0}};
    for (int c = 0; c < CH; c++) begin
      hcur_s = s1_h_r[c*H_W +: H_W];
      hbuf_s = rd_data_r[c*H_W +: H_W];
      hor_s  = hcur_s + H_W'(1);
      box_s  = {1'b0, hbuf_s} + {1'b0, hcur_s} + (H_W+1)'(2);
      case (s1_kind_r)
        MODE_BYP: out_s[c*CH_W +: CH_W] = s1_pix_r[c*CH_W +: CH_W];
        MODE_HOR: out_s[c*CH_W +: CH_W] = CH_W'(hor_s >> 1);
        MODE_BOX: out_s[c*CH_W +: CH_W] = CH_W'(box_s >> 2);
        default:  out_s[c*CH_W +: CH_W] = s1_pix_r[c*CH_W +: CH_W];
      endcase
    end
  end

  // Stage 2: registered outputs, pixel forced to zero when not valid
  always_ff @(posedge pixclk_in or posedge rst) begin
    if (rst) begin
      de_out_r  <= 1'b0;
      o_pixel_r <= {PIX_W{1'b0}};
    end else begin
      de_out_r  <= s1_vld_r;
      o_pixel_r <= s1_vld_r ? out_s : {PIX_W{1'b0}};
    end
  end

endmodule

// File: doc/image_downscale_2x2.md
# image_downscale_2x2

Parametrised 2:1 video downscaler with selectable mode: bypass, horizontal-only 2:1, or full 2×2 box average with round-to-nearest. It sits between the pixel-source capture stage and the frame writer on the pixel clock domain. It generalises the fixed 24-bit RGB halver to any channel count and width. It adds rounding, odd-width/overlong-line handling and a fixed pipeline latency.

## Interface
- CH, 3, number of colour channels packed in a pixel (channel 0 in LSBs)
- CH_W, 8, bits per channel
- MAX_SRC_W, 1280, maximum source line length in pixels (even, ≥2)
- ADDR_W, $clog2(MAX_SRC_W/2), line-buffer address width
- pixclk_in  input  1  pixel clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- vs_in  input  1  frame-start pulse, one cycle, asserted while de_in low
- mode_in  input  2  00 bypass, 01 horizontal 2:1, 10 2×2 average, 11 treated as 00
- de_in  input  1  pixel valid; high for the whole active part of a line
- i_pixel  input  CH*CH_W  input pixel
- de_out  output  1  output pixel valid
- o_pixel  output  CH*CH_W  output pixel, all-zero whenever de_out low
- line_ovf  output  1  sticky: a line exceeded MAX_SRC_W pixels; cleared by vs_in

## Operation
- Mode latched from mode_in on the vs_in cycle and held for the frame; mid-frame mode_in changes have no effect. After reset the latched mode is 00.
- x counter (width clog2(MAX_SRC_W)+1) counts accepted pixels in the current line. It clears to 0 on de_in falling edge and on vs_in.
- Line parity bit: cleared by vs_in and reset. Toggles on de_in falling edge only if the line had ≥1 pixel.
- Bypass: every de_in pixel is forwarded unchanged.
- Horizontal 2:1: even-x pixel held in register P. On odd-x pixel, per channel output is (P + cur + 1) >> 1, using a CH_W+1-bit sum. Every line produces output.
- 2×2: per-channel horizontal sum H = P + cur (CH_W+1 bits, unrounded).
  - Even-parity line: H written to line buffer at address x>>1; no output.
  - Odd-parity line: buffer read at x>>1. Output per channel is (Hbuf + H + 2) >> 2, using a CH_W+2-bit sum, truncated to CH_W.
- Line buffer: MAX_SRC_W/2 entries × CH*(CH_W+1) bits, simple dual-port, synchronous read, inferred RAM.
- Odd line length: final unpaired pixel discarded; P is not carried to the next line.
- Pixels with x ≥ MAX_SRC_W are discarded (no write, no output) and set line_ovf.
- Odd-parity line longer than the preceding even line: buffer entries beyond the even line's length hold stale data. Output is still produced; correctness is not required there.
- Frame with an odd number of lines: last line stored, never output.
- Reset: x, parity, P, pipeline, line_ovf and latched mode all cleared. Buffer contents are not cleared; they are unreachable until rewritten, because parity restarts even.

## Timing
- Reset values: de_out=0, o_pixel=0, line_ovf=0.
- Fixed latency 2 cycles in every mode, from the accepting edge of the producing input pixel to de_out/o_pixel.
  - Producing pixel in bypass: every pixel.
  - Producing pixel in the other modes: the odd-x pixel.
- Stage 1 (edge after acceptance): H/pass-through registered; buffer read address presented on the accept cycle, read data available in stage 1; buffer write on even lines happens at stage 1.
- Stage 2: final add/round registered into o_pixel, de_out=1 for exactly one cycle per output pixel.
- Throughput: bypass 1 pixel/cycle; 2:1 modes one output per two input pixels, de_out toggling 1/0 for continuous input.
- Back-to-back lines with a one-cycle de_in gap are supported. Parity toggle and x clear take effect for the first pixel of the next line.
- vs_in coincident with in-flight stage 1/2 data: in-flight outputs still emerge unchanged; new mode applies to the next accepted pixel.
- Async rst mid-line: outputs drop to 0 immediately; no partial pixel emitted after release.

## Test plan
- Bypass: 8-pixel line 0x010203..0x080808 (CH=3, CH_W=8) -> identical 8 pixels, each 2 cycles after input, o_pixel=0 between lines.
- Horizontal rounding: pixels ch0 = 0x01,0x02 then 0xFF,0xFE -> outputs ch0 0x02, 0xFF; de_out pulses 2 cycles after each odd pixel.
- 2×2: line0 ch0 = 10,11; line1 ch0 = 12,14 -> single output 12 ((21+26+2)>>2); no output during line0. Also all-0xFF 2×2 block -> 0xFF with no overflow wrap.
- Odd width and overflow: MAX_SRC_W=8, line of 9 pixels in 2×2 -> 4 outputs on odd line, line_ovf=1, cleared by next vs_in. Line of 5 -> 2 outputs, 5th pixel ignored.
- Mode latch: switch mode_in 10→00 mid-frame -> frame continues 2×2; after next vs_in, bypass output.
- Async reset asserted mid odd-line with a pixel in stage 1 -> de_out=0 and o_pixel=0 at once. After release, next frame line0 produces no output and line1 averages correctly.
